// File: rtl/vc_queue_pkg.sv
// Shared queue-mode constants and the mode legality check used by the vc queue family.
package vc_queue_pkg;

  localparam int unsigned VC_QUEUE_NORMAL = 0;
  localparam int unsigned VC_QUEUE_PIPE   = 1;
  localparam int unsigned VC_QUEUE_BYPASS = 2;

  // BYPASS would need a same-cycle enq->deq path, which these queues do not have.
  function automatic bit vc_queue_type_legal(input int unsigned qtype);
    return (qtype == VC_QUEUE_NORMAL) || (qtype == VC_QUEUE_PIPE);
  endfunction

endpackage

// File: rtl/vc_Regfile_1r1w.sv
// One-read one-write register file: combinational read, clocked write, storage not reset.
module vc_Regfile_1r1w #(
  parameter int unsigned p_data_nbits  = 32,
  parameter int unsigned p_num_entries = 2,
  parameter int unsigned c_addr_nbits  = $clog2(p_num_entries)
)(
  input  logic                    clk,
  input  logic [c_addr_nbits-1:0] read_addr,
  output logic [p_data_nbits-1:0] read_data,
  input  logic                    write_en,
  input  logic [c_addr_nbits-1:0] write_addr,
  input  logic [p_data_nbits-1:0] write_data
);

  logic [p_data_nbits-1:0] rfile [p_num_entries];

  assign read_data = rfile[read_addr];

  always_ff @(posedge clk) begin
    if (write_en) rfile[write_addr] <= write_data;
  end

endmodule

// File: rtl/vc_rr_arb_hold.sv
// Round-robin arbiter whose grant is frozen while the granted requester is stalled.
module vc_rr_arb_hold #(
  parameter  int unsigned p_num_reqs  = 4,
  localparam int unsigned c_idx_nbits = $clog2(p_num_reqs)
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic [p_num_reqs-1:0]  req_i,
  input  logic                   hold_i,
  input  logic                   advance_i,
  output logic [p_num_reqs-1:0]  grant_oh_c,
  output logic [c_idx_nbits-1:0] grant_idx_c
);

  logic [c_idx_nbits-1:0] rr_ptr_q, rr_ptr_d;
  logic [c_idx_nbits-1:0] lock_chan_q, lock_chan_d;
  logic                   lock_q, lock_d;
  logic [c_idx_nbits-1:0] scan_idx;
  logic                   scan_found;
  int unsigned            cand;

  // First requester at or above rr_ptr, wrapping; defaults to 0 when idle.
  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    cand       = 0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      cand = (32'(rr_ptr_q) + i) % p_num_reqs;
      if (!scan_found && req_i[cand]) begin
        scan_found = 1'b1;
        scan_idx   = c_idx_nbits'(cand);
      end
    end
  end

  always_comb begin
    grant_idx_c = lock_q ? lock_chan_q : scan_idx;
    grant_oh_c  = '0;
    if (lock_q || scan_found) grant_oh_c[grant_idx_c] = 1'b1;
  end

  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush_i) begin
      lock_d      = 1'b0;
      lock_chan_d = '0;
      rr_ptr_d    = '0;
    end else if (advance_i) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant_idx_c == c_idx_nbits'(p_num_reqs - 1))
                 ? '0 : grant_idx_c + c_idx_nbits'(1);
    end else if (hold_i) begin
      lock_d      = 1'b1;
      lock_chan_d = grant_idx_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/vc_mchan_queue.sv
// Multi-channel message queue: per-channel FIFOs in one shared regfile, steered enqueue,
// round-robin dequeue with grant hold, synchronous flush and optional pipe behaviour.
module vc_mchan_queue
  import vc_queue_pkg::*;
#(
  parameter  int unsigned p_type       = VC_QUEUE_NORMAL,
  parameter  int unsigned p_msg_nbits  = 32,
  parameter  int unsigned p_num_msgs   = 4,
  parameter  int unsigned p_num_chans  = 4,
  localparam int unsigned c_chan_nbits = $clog2(p_num_chans),
  localparam int unsigned c_cnt_nbits  = $clog2(p_num_msgs + 1)
)(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 flush,
  input  logic                                 enq_val,
  output logic                                 enq_rdy,
  input  logic [c_chan_nbits-1:0]              enq_chan,
  input  logic [p_msg_nbits-1:0]               enq_msg,
  output logic                                 deq_val,
  input  logic                                 deq_rdy,
  output logic [c_chan_nbits-1:0]              deq_chan,
  output logic [p_msg_nbits-1:0]               deq_msg,
  output logic [p_num_chans*c_cnt_nbits-1:0]   num_free_entries
);

  localparam int unsigned c_slot_nbits  = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam int unsigned c_num_entries = p_num_chans * p_num_msgs;
  localparam int unsigned c_addr_nbits  = $clog2(c_num_entries);
  localparam bit          c_pipe        = (p_type == VC_QUEUE_PIPE);

  if (!vc_queue_type_legal(p_type)) begin : g_bad_type
    $error("vc_mchan_queue: illegal p_type %0d (only NORMAL or PIPE)", p_type);
  end

  logic [p_num_chans-1:0][c_cnt_nbits-1:0]  count;
  logic [p_num_chans-1:0][c_slot_nbits-1:0] head;
  logic [p_num_chans-1:0][c_slot_nbits-1:0] tail;
  logic [p_num_chans-1:0]                   nonempty;
  logic [p_num_chans-1:0]                   grant_oh;
  logic [c_chan_nbits-1:0]                  grant_idx;
  logic                                     enq_chan_ok, enq_full, pipe_ok;
  logic                                     do_enq, do_deq;
  logic [c_addr_nbits-1:0]                  wr_addr, rd_addr;

  // Per-channel lookups by mux, so an out-of-range enq_chan selects nothing.
  always_comb begin
    enq_chan_ok = 1'b0;
    enq_full    = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
    for (int unsigned c = 0; c < p_num_chans; c++) begin
      if (enq_chan == c_chan_nbits'(c)) begin
        enq_chan_ok = 1'b1;
        enq_full    = (count[c] == c_cnt_nbits'(p_num_msgs));
        wr_addr     = c_addr_nbits'(c * p_num_msgs) + c_addr_nbits'(tail[c]);
      end
      if (grant_idx == c_chan_nbits'(c))
        rd_addr = c_addr_nbits'(c * p_num_msgs) + c_addr_nbits'(head[c]);
    end
  end

  // A locked channel is always non-empty, so non-empty alone covers the lock.
  assign deq_val  = ~flush & (|nonempty);
  assign deq_chan = grant_idx;
  assign do_deq   = deq_val & deq_rdy;
  assign pipe_ok  = c_pipe & enq_full & do_deq & (deq_chan == enq_chan);
  assign enq_rdy  = ~flush & enq_chan_ok & (~enq_full | pipe_ok);
  assign do_enq   = enq_val & enq_rdy;

  vc_rr_arb_hold #(.p_num_reqs(p_num_chans)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush),
    .req_i       (nonempty),
    .hold_i      (deq_val & ~deq_rdy),
    .advance_i   (do_deq),
    .grant_oh_c  (grant_oh),
    .grant_idx_c (grant_idx)
  );

  vc_Regfile_1r1w #(
    .p_data_nbits  (p_msg_nbits),
    .p_num_entries (c_num_entries),
    .c_addr_nbits  (c_addr_nbits)
  ) u_rf (
    .clk        (clk),
    .read_addr  (rd_addr),
    .read_data  (deq_msg),
    .write_en   (do_enq),
    .write_addr (wr_addr),
    .write_data (enq_msg)
  );

  for (genvar c = 0; c < p_num_chans; c++) begin : g_chan
    logic                    enq_here, deq_here;
    logic [c_cnt_nbits-1:0]  count_q, count_d;
    logic [c_slot_nbits-1:0] head_q, head_d, tail_q, tail_d;

    assign enq_here    = do_enq & (enq_chan == c_chan_nbits'(c));
    assign deq_here    = do_deq & grant_oh[c];
    assign count[c]    = count_q;
    assign head[c]     = head_q;
    assign tail[c]     = tail_q;
    assign nonempty[c] = (count_q != '0);
    assign num_free_entries[c*c_cnt_nbits +: c_cnt_nbits] = c_cnt_nbits'(p_num_msgs) - count_q;

    always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
        count_d = '0;
        head_d  = '0;
        tail_d  = '0;
      end else begin
        if (enq_here)
          tail_d = (tail_q == c_slot_nbits'(p_num_msgs - 1)) ? '0 : tail_q + c_slot_nbits'(1);
        if (deq_here)
          head_d = (head_q == c_slot_nbits'(p_num_msgs - 1)) ? '0 : head_q + c_slot_nbits'(1);
        if (enq_here && !deq_here)      count_d = count_q + c_cnt_nbits'(1);
        else if (!enq_here && deq_here) count_d = count_q - c_cnt_nbits'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        count_q <= count_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
      end
    end
  end

endmodule

// File: tb/tb_vc_mchan_queue.sv
// Bench for vc_mchan_queue: NORMAL and PIPE instances share stimulus and a (chan,msg) scoreboard.
module tb_vc_mchan_queue;
  import vc_queue_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned NM = 4;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] msg;
  } sb_t;

  logic        clk, reset_n, flush, enq_val, deq_rdy;
  logic [1:0]  enq_chan;
  logic [31:0] enq_msg;

  logic        n_enq_rdy, n_deq_val, p_enq_rdy, p_deq_val;
  logic [1:0]  n_deq_chan, p_deq_chan;
  logic [31:0] n_deq_msg, p_deq_msg;
  logic [11:0] n_free, p_free;

  sb_t sb[$];
  int  cnt [NC];
  int  n_chk = 0;
  int  n_fail = 0;

  vc_mchan_queue #(.p_type(VC_QUEUE_NORMAL), .p_msg_nbits(32), .p_num_msgs(NM), .p_num_chans(NC)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_val(enq_val), .enq_rdy(n_enq_rdy), .enq_chan(enq_chan), .enq_msg(enq_msg),
    .deq_val(n_deq_val), .deq_rdy(deq_rdy), .deq_chan(n_deq_chan), .deq_msg(n_deq_msg),
    .num_free_entries(n_free)
  );

  vc_mchan_queue #(.p_type(VC_QUEUE_PIPE), .p_msg_nbits(32), .p_num_msgs(NM), .p_num_chans(NC)) dut_p (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .enq_val(enq_val), .enq_rdy(p_enq_rdy), .enq_chan(enq_chan), .enq_msg(enq_msg),
    .deq_val(p_deq_val), .deq_rdy(deq_rdy), .deq_chan(p_deq_chan), .deq_msg(p_deq_msg),
    .num_free_entries(p_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] free_exp();
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*CW +: CW] = CW'(NM - cnt[i]);
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    sb.delete();
  endtask

  task automatic enq(input logic [1:0] ch, input logic [31:0] msg);
    sb_t e;
    enq_val = 1'b1; enq_chan = ch; enq_msg = msg;
    @(negedge clk);
    chk("enq n enq_rdy", n_enq_rdy, 1);
    chk("enq p enq_rdy", p_enq_rdy, 1);
    @(posedge clk); #1;
    enq_val = 1'b0;
    e.chan = ch; e.msg = msg;
    sb.push_back(e);
    cnt[ch]++;
  endtask

  task automatic check_head(input string tag, input sb_t e);
    chk({tag, " n deq_val"},  n_deq_val, 1);
    chk({tag, " n deq_chan"}, n_deq_chan, e.chan);
    chk({tag, " n deq_msg"},  n_deq_msg, e.msg);
    chk({tag, " p deq_val"},  p_deq_val, 1);
    chk({tag, " p deq_chan"}, p_deq_chan, e.chan);
    chk({tag, " p deq_msg"},  p_deq_msg, e.msg);
  endtask

  // Accept one message this cycle; leaves deq_rdy high for back-to-back calls.
  task automatic deq_one(input string tag);
    sb_t e;
    deq_rdy = 1'b1;
    @(negedge clk);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check_head(tag, e);
    @(posedge clk); #1;
    cnt[e.chan]--;
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    @(negedge clk);
    chk({tag, " n enq_rdy"}, n_enq_rdy, 0);
    chk({tag, " n deq_val"}, n_deq_val, 0);
    chk({tag, " p deq_val"}, p_deq_val, 0);
    @(posedge clk); #1;
    flush = 1'b0; enq_val = 1'b0;
    clear_model();
    @(negedge clk);
    chk({tag, " after n free"}, n_free, free_exp());
    chk({tag, " after p free"}, p_free, free_exp());
    chk({tag, " after n deq_val"}, n_deq_val, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    sb_t e;
    reset_n = 1'b0; flush = 1'b0; enq_val = 1'b0; enq_chan = '0; enq_msg = '0; deq_rdy = 1'b0;
    clear_model();
    #12;
    chk("rst n deq_val", n_deq_val, 0);
    chk("rst n deq_chan", n_deq_chan, 0);
    chk("rst n enq_rdy", n_enq_rdy, 1);
    chk("rst n free", n_free, free_exp());
    chk("rst p deq_val", p_deq_val, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Fill chan 2, then probe a full channel and an empty one.
    for (int i = 0; i < 4; i++) enq(2'd2, 32'(32'hA0 + i));
    enq_val = 1'b1; enq_chan = 2'd2; enq_msg = 32'hA4;
    @(negedge clk);
    chk("t1 full n enq_rdy", n_enq_rdy, 0);
    chk("t1 full p enq_rdy", p_enq_rdy, 0);
    #1 enq_chan = 2'd0;
    #1 chk("t1 ch0 enq_rdy", n_enq_rdy, 1);
    enq_val = 1'b0;
    chk("t1 n free", n_free, free_exp());
    chk("t1 n free lit", n_free, 12'b100_000_100_100);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) deq_one("t1 drain");
    deq_rdy = 1'b0;
    do_flush("t1 flush");

    // Round-robin order from rr_ptr=0.
    enq(2'd0, 32'h10); enq(2'd1, 32'h11); enq(2'd3, 32'h13);
    deq_one("t2 d0"); deq_one("t2 d1"); deq_one("t2 d3");
    @(negedge clk);
    chk("t2 empty deq_val", n_deq_val, 0);
    @(posedge clk); #1 deq_rdy = 1'b0;

    // Locked grant on chan 1 survives a later arrival on chan 0.
    enq(2'd1, 32'h55);
    enq_val = 1'b1; enq_chan = 2'd0; enq_msg = 32'h66;
    @(negedge clk);
    chk("t3 enq_rdy", n_enq_rdy, 1);
    check_head("t3 hold0", sb[0]);
    @(posedge clk); #1;
    enq_val = 1'b0;
    e.chan = 2'd0; e.msg = 32'h66; sb.push_back(e); cnt[0]++;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check_head("t3 hold", sb[0]);
      @(posedge clk); #1;
    end
    deq_one("t3 acc55");
    deq_one("t3 acc66");
    deq_rdy = 1'b0;

    // Full chan 0 with simultaneous deq+enq: PIPE accepts, NORMAL refuses.
    for (int i = 0; i < 4; i++) enq(2'd0, 32'(32'hB0 + i));
    deq_rdy = 1'b1; enq_val = 1'b1; enq_chan = 2'd0; enq_msg = 32'h77;
    @(negedge clk);
    chk("t5 n enq_rdy full", n_enq_rdy, 0);
    chk("t4 p enq_rdy pipe", p_enq_rdy, 1);
    e = sb.pop_front();
    check_head("t45 headB0", e);
    @(posedge clk); #1;
    deq_rdy = 1'b0;
    @(negedge clk);
    cnt[0] = 3;
    chk("t5 n free after deq", n_free, free_exp());
    cnt[0] = 4;
    chk("t4 p free after pipe", p_free, free_exp());
    chk("t5 n enq_rdy retry", n_enq_rdy, 1);
    chk("t4 p enq_rdy full", p_enq_rdy, 0);
    @(posedge clk); #1;
    enq_val = 1'b0;
    e.chan = 2'd0; e.msg = 32'h77; sb.push_back(e);
    for (int i = 0; i < 4; i++) deq_one("t45 drain");
    deq_rdy = 1'b0;

    // Flush while locked with two channels pending, then fresh traffic on chan 3.
    enq(2'd1, 32'hC1); enq(2'd2, 32'hC2);
    enq_val = 1'b1; enq_chan = 2'd3; enq_msg = 32'hFF;
    do_flush("t6 flush");
    enq(2'd3, 32'hD3);
    deq_one("t6 d3");
    deq_rdy = 1'b0;

    // Asynchronous reset between clock edges.
    enq(2'd0, 32'hE0);
    #1 chk("arst pre deq_val", n_deq_val, 1);
    #1 reset_n = 1'b0;
    clear_model();
    #1;
    chk("arst n deq_val", n_deq_val, 0);
    chk("arst p deq_val", p_deq_val, 0);
    chk("arst n free", n_free, free_exp());
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("arst post enq_rdy", n_enq_rdy, 1);
    chk("arst post deq_val", n_deq_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
